// File: rtl/axilite_read_channel.sv
// AXI4-Lite slave read path: accepts one read address at a time, selects the
// addressed word from the flat register vector and returns it with a response.
// Every output is driven straight from a flop.

module axilite_read_channel #(
    parameter int unsigned DATA_SIZE   = 128,
    parameter int unsigned ADDR_SIZE   = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned RESP_OKAY   = 0,
    parameter int unsigned RESP_SLVERR = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_SIZE-1:0]  araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [DATA_SIZE-1:0]  regs
);

    localparam int unsigned NUM_REGS = DATA_SIZE / DATA_WIDTH;
    localparam int unsigned LSB      = $clog2(DATA_WIDTH / 8);

    typedef enum logic {StIdle, StResp} state_e;

    state_e                state_q, state_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic [ADDR_SIZE-1:0]  idx;
    logic                  in_range;
    logic [DATA_WIDTH-1:0] word_sel;

    // Decode the word index; the full upper address is kept so aliases of
    // in-range words above the vector are reported as errors.
    always_comb begin
        idx      = araddr >> LSB;
        in_range = (idx < ADDR_SIZE'(NUM_REGS));
        word_sel = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (idx == ADDR_SIZE'(k)) begin
                word_sel = regs[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and registered-output logic for the two-state handshake FSM.
    always_comb begin
        state_d   = state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        unique case (state_q)
            StIdle: begin
                // arready comes up on the first edge after reset release
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                if (arvalid && arready_q) begin
                    state_d   = StResp;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = in_range ? word_sel : '0;
                    rresp_d   = in_range ? 2'(RESP_OKAY) : 2'(RESP_SLVERR);
                end
            end
            StResp: begin
                // rdata/rresp hold until the beat is taken, and keep their values after
                if (rready) begin
                    state_d   = StIdle;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_axilite_read_channel.sv
// Scoreboard bench for axilite_read_channel: directed scenarios followed by
// randomized reads; expected responses come from an address-arithmetic model.

module tb_axilite_read_channel;

    logic         clk;
    logic         rst;
    logic [31:0]  araddr;
    logic         arvalid;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready;
    logic [127:0] regs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cyc = -10;
    logic [33:0] sb[$];
    int r_cycs[$];

    axilite_read_channel #(
        .DATA_SIZE  (128),
        .ADDR_SIZE  (32),
        .DATA_WIDTH (32),
        .RESP_OKAY  (0),
        .RESP_SLVERR(2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .araddr (araddr),
        .arvalid(arvalid),
        .arready(arready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rvalid (rvalid),
        .rready (rready),
        .regs   (regs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: word index = byte address / 4, four words in the vector.
    function automatic logic [33:0] model(input logic [31:0] addr, input logic [127:0] r);
        logic [31:0] widx;
        widx = addr / 4;
        if (widx < 4) return {r[widx*32 +: 32], 2'd0};
        return {32'd0, 2'd2};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Push side: an accepted address produces one expected response.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && arvalid && arready) begin
                sb.push_back(model(araddr, regs));
                hs_cyc = cyc;
            end
        end
    end

    // Monitor: compares every presented R beat against the scoreboard head.
    initial begin
        logic [33:0] exp;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (cyc == hs_cyc + 1) chk("rvalid_latency", rvalid, 1'b1);
                if (rvalid) begin
                    chk("arready_low_while_rvalid", arready, 1'b0);
                    if (sb.size() == 0) begin
                        timeout("unexpected_rvalid_no_pending_read");
                    end else begin
                        exp = sb[0];
                        chk("rdata", rdata, exp[33:2]);
                        chk("rresp", rresp, exp[1:0]);
                        if (rready) begin
                            void'(sb.pop_front());
                            r_cycs.push_back(cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic wait_ar_hs();
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (arvalid && arready) return;
        end
        timeout("ar_handshake");
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !rvalid) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        timeout("r_handshake");
        @(posedge clk);
        #1;
    endtask

    task automatic read(input logic [31:0] addr, input int rlow);
        int w;
        araddr  = addr;
        arvalid = 1'b1;
        rready  = (rlow == 0);
        wait_ar_hs();
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        for (int i = 0; i < rlow; i++) begin
            w = $urandom_range(0, 3);
            regs[w*32 +: 32] = $urandom;
            @(posedge clk);
            #1;
        end
        rready = 1'b1;
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] addr;
        rst     = 1'b0;
        arvalid = 1'b0;
        araddr  = '0;
        rready  = 1'b0;
        regs    = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};

        // Reset state, then a premature arvalid that must not be accepted
        repeat (3) @(posedge clk);
        #1;
        chk("reset_arready", arready, 1'b0);
        chk("reset_rvalid", rvalid, 1'b0);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_rresp", rresp, 2'd0);
        rst     = 1'b1;
        arvalid = 1'b1;
        araddr  = 32'h0;
        @(negedge clk);
        chk("arready_before_first_edge", arready, 1'b0);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        chk("arready_after_first_edge", arready, 1'b1);
        chk("rvalid_after_first_edge", rvalid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("no_txn_from_dropped_arvalid", rvalid, 1'b0);

        // In-range, out-of-range and unaligned reads
        read(32'h8, 0);
        read(32'h10, 0);
        read(32'hFFFF_FFFC, 0);
        read(32'h6, 0);

        // Backpressure with regs changing and a second address waiting
        araddr  = 32'h4;
        arvalid = 1'b1;
        rready  = 1'b0;
        wait_ar_hs();
        @(posedge clk);
        #1;
        araddr = 32'h0;
        regs[63:32] = 32'h12345678;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("arready_held_low_backpressure", arready, 1'b0);
        chk("rdata_held_backpressure", rdata, 32'hBBBB0001);
        rready = 1'b1;
        wait_ar_hs();
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        wait_idle();

        // Back-to-back reads with arvalid held high
        regs = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
        r_cycs.delete();
        araddr  = 32'h0;
        arvalid = 1'b1;
        rready  = 1'b1;
        wait_ar_hs();
        @(posedge clk);
        #1;
        araddr = 32'h4;
        wait_ar_hs();
        @(posedge clk);
        #1;
        araddr = 32'hC;
        wait_ar_hs();
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        wait_idle();
        chk("b2b_beat_count", r_cycs.size(), 3);
        if (r_cycs.size() == 3) begin
            chk("b2b_spacing_1", r_cycs[1] - r_cycs[0], 2);
            chk("b2b_spacing_2", r_cycs[2] - r_cycs[1], 2);
        end

        // Reset while a response is pending
        araddr  = 32'h4;
        arvalid = 1'b1;
        rready  = 1'b0;
        wait_ar_hs();
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_rvalid", rvalid, 1'b0);
        chk("async_reset_arready", arready, 1'b0);
        chk("async_reset_rdata", rdata, 32'd0);
        chk("async_reset_rresp", rresp, 2'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b1;
        rready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale_beat_after_reset", rvalid, 1'b0);
        read(32'h0, 0);

        // Randomized reads with random backpressure and register updates
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) addr = $urandom;
            else addr = $urandom_range(0, 23);
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 3)*32 +: 32] = $urandom;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            read(addr, $urandom_range(0, 3));
        end
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axilite_read_channel.md
Name: axilite_read_channel

Overview:
AXI4-Lite slave read path for the CSR block: accepts a read address, selects one DATA_WIDTH word from the flat register vector, and returns it with a response code. It sits beside axilite_write_channel, which writes the vector. The write channel's regs output connects to this block's regs input, so software can read back the control registers. One outstanding transaction at a time; no read pipelining.

Parameters:
DATA_SIZE, 128, total width of the register vector (multiple of DATA_WIDTH)
ADDR_SIZE, 32, width of araddr
DATA_WIDTH, 32, AXI data bus width (32 or 64)
RESP_OKAY, 0, response code for a successful read
RESP_SLVERR, 2, response code for an out-of-range address

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
araddr  input  ADDR_SIZE  read byte address
arvalid  input  1  read address valid
arready  output  1  read address ready
rdata  output  DATA_WIDTH  read data
rresp  output  2  read response
rvalid  output  1  read data valid
rready  input  1  master ready for read data
regs  input  DATA_SIZE  flat register vector; word k = regs[k*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset value of all outputs is 0: arready=0, rvalid=0, rdata=0, rresp=0, FSM=IDLE. Reset applies immediately, without waiting for a clock edge.
- Derived values:
  - NUM_REGS = DATA_SIZE/DATA_WIDTH
  - LSB = log2(DATA_WIDTH/8)
  - word index idx = araddr >> LSB, full remaining width, no truncation
  - araddr[LSB-1:0] is ignored: unaligned addresses read the containing word
- All outputs are registered; no combinational path from any input to any output.
- FSM has two states, IDLE and RESP.
- IDLE:
  - arready=1, rvalid=0
  - First rising edge after reset release only sets arready=1; no AR transfer can complete before that.
  - On an edge where arvalid && arready:
    - capture the response: if idx < NUM_REGS, rdata = word idx of regs sampled on that edge, rresp = RESP_OKAY; otherwise rdata = 0, rresp = RESP_SLVERR
    - set rvalid=1 and arready=0, go to RESP
  - Latency: AR handshake at edge N, rvalid visible after edge N.
- RESP:
  - rvalid=1, arready=0
  - rdata and rresp are held stable until the R handshake, even if regs or araddr change.
  - On an edge where rvalid && rready: rvalid=0, arready=1, go to IDLE.
  - rdata and rresp keep their last values after the handshake and are don't-care while rvalid=0.
- Throughput: at most one read per 2 cycles. A new address cannot be accepted in the same cycle that the R handshake completes.
- rready held high before rvalid rises: the handshake completes on the first edge where rvalid=1.
- arvalid dropped before arready (protocol violation): no transaction; the block stays in IDLE.
- Reset asserted mid-transaction (in RESP): the pending response is discarded, all outputs go to 0, and no R beat is issued after release.
- A simultaneous write to the same register through axilite_write_channel on the capture edge returns the pre-write value, i.e. regs as sampled on that edge.

Test Plan:
1. Reset release: hold rst=0 for 3 cycles, then release. Outputs are 0 during reset; arready=1 after the first edge; rvalid stays 0.
2. In-range read: regs = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000}, araddr=0x8, arvalid for one cycle, rready=1. Response is rdata=32'hCCCC0002, rresp=0, rvalid high exactly one cycle after the AR handshake.
3. Out-of-range and unaligned reads:
   - araddr=0x10 returns rresp=2, rdata=0
   - araddr=0xFFFF_FFFC returns rresp=2
   - araddr=0x6 returns the word at 0x4, rdata=32'hBBBB0001, rresp=0
4. Backpressure: rready=0 for 5 cycles after rvalid rises while regs word 1 changes to 32'h12345678. rdata stays 32'hBBBB0001 and rvalid stays 1. arready stays 0 while arvalid is asserted with a second address. After rready=1, the second read is accepted and returns its own word.
5. Back-to-back reads: arvalid held high with addresses 0x0, 0x4, 0xC and rready=1. Three R beats return AAAA0000, BBBB0001, DDDD0003 in order, at one beat per 2 cycles.
6. Reset mid-response: assert rst while rvalid=1 and rready=0. rvalid drops immediately, without waiting for a clock edge. After release, no stale R beat appears, and a fresh read of 0x0 returns 32'hAAAA0000.
